// File: rtl/ddr_frame_align.sv
// DDR frame aligner: picks the half-cycle pairing of rise/fall samples
// whose frame lane reads 1-then-0, locks after a run of matches.
//
// Ports:
//   clk, reset              single clock, sync active-high reset
//   data_rise, data_fall    samples taken on each clk edge
//   frame_rise, frame_fall  frame lane samples on each clk edge
//   realign                 one-cycle request to drop lock and search
//   sample0, sample1        aligned pair (earlier, later), 1-cycle latency
//   data_valid              pair was taken while LOCKED
//   locked                  FSM in LOCKED
//   slip                    current half-cycle alignment select
//   err_count               mismatches while LOCKED (saturating)
//
// Option: define DDR_FRAME_ALIGN_ERRCNT_EN to build the error counter;
// otherwise err_count is tied to zero.

module ddr_frame_align #(
   parameter int width      = 8,
   parameter int lock_count = 16,
   parameter int slip_wait  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] data_rise,
   input  logic [width-1:0] data_fall,
   input  logic             frame_rise,
   input  logic             frame_fall,
   input  logic             realign,
   output logic [width-1:0] sample0,
   output logic [width-1:0] sample1,
   output logic             data_valid,
   output logic             locked,
   output logic             slip,
   output logic [15:0]      err_count
);

   typedef enum logic [1:0] {
      SEARCH,
      CHECK,
      WAIT,
      LOCKED
   } state_t;

   localparam logic [7:0] LOCK_N = 8'(lock_count);
   localparam logic [3:0] WAIT_N = 4'(slip_wait);

   state_t           state;
   state_t           state_nxt;
   logic             slip_nxt;
   logic [7:0]       match_cnt;
   logic [7:0]       match_nxt;
   logic [3:0]       wait_cnt;
   logic [3:0]       wait_nxt;
   logic [2:0]       miss_cnt;
   logic [2:0]       miss_nxt;

   logic [width-1:0] prev_fall;
   logic             prev_frame_fall;

   logic [width-1:0] s0;
   logic [width-1:0] s1;
   logic             f0;
   logic             f1;
   logic             match;

   // slip=1 pairs last cycle's fall sample with this cycle's rise
   always_comb begin
      s0 = data_rise;
      s1 = data_fall;
      f0 = frame_rise;
      f1 = frame_fall;
      if (slip) begin
         s0 = prev_fall;
         s1 = data_rise;
         f0 = prev_frame_fall;
         f1 = frame_rise;
      end
   end

   assign match  = f0 & ~f1;
   assign locked = (state == LOCKED);

   always_comb begin
      state_nxt = state;
      slip_nxt  = slip;
      match_nxt = match_cnt;
      wait_nxt  = wait_cnt;
      miss_nxt  = miss_cnt;
      if (realign) begin
         state_nxt = SEARCH;
         match_nxt = '0;
         wait_nxt  = '0;
         miss_nxt  = '0;
      end else begin
         unique case (state)
            SEARCH: begin
               if (match) begin
                  state_nxt = CHECK;
                  match_nxt = 8'd1;
               end else begin
                  state_nxt = WAIT;
                  slip_nxt  = ~slip;
                  wait_nxt  = '0;
               end
            end
            WAIT: begin
               if (wait_cnt == WAIT_N - 4'd1) begin
                  state_nxt = SEARCH;
                  wait_nxt  = '0;
               end else begin
                  wait_nxt = wait_cnt + 4'd1;
               end
            end
            CHECK: begin
               if (match) begin
                  if (match_cnt + 8'd1 == LOCK_N) begin
                     state_nxt = LOCKED;
                     match_nxt = '0;
                  end else begin
                     match_nxt = match_cnt + 8'd1;
                  end
               end else begin
                  state_nxt = WAIT;
                  slip_nxt  = ~slip;
                  match_nxt = '0;
                  wait_nxt  = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  miss_nxt = '0;
               end else if (miss_cnt == 3'd3) begin
                  state_nxt = WAIT;
                  slip_nxt  = ~slip;
                  miss_nxt  = '0;
                  wait_nxt  = '0;
               end else begin
                  miss_nxt = miss_cnt + 3'd1;
               end
            end
            default: begin
               state_nxt = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= SEARCH;
         slip            <= 1'b0;
         match_cnt       <= '0;
         wait_cnt        <= '0;
         miss_cnt        <= '0;
         prev_fall       <= '0;
         prev_frame_fall <= 1'b0;
         sample0         <= '0;
         sample1         <= '0;
         data_valid      <= 1'b0;
      end else begin
         state           <= state_nxt;
         slip            <= slip_nxt;
         match_cnt       <= match_nxt;
         wait_cnt        <= wait_nxt;
         miss_cnt        <= miss_nxt;
         prev_fall       <= data_fall;
         prev_frame_fall <= frame_fall;
         sample0         <= s0;
         sample1         <= s1;
         // a realign discards the pair captured in the same cycle
         data_valid      <= (state == LOCKED) & ~realign;
      end
   end

`ifdef DDR_FRAME_ALIGN_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= '0;
      end else if (state == LOCKED && !match
                   && err_count != 16'hFFFF) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: doc/ddr_frame_align.md
DDR_FRAME_ALIGN -- requirements
Module: ddr_frame_align

Interface
REQ-001 SHALL have parameter width, default 8, meaning data bits captured per clock edge.
REQ-002 SHALL have parameter lock_count, default 16, meaning consecutive frame matches required to lock (range 2..255).
REQ-003 SHALL have parameter slip_wait, default 4, meaning settle cycles after each slip toggle (range 1..15).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port data_rise, input, width, meaning data captured on the rising edge.
REQ-007 SHALL have port data_fall, input, width, meaning data captured on the falling edge, same clk cycle.
REQ-008 SHALL have port frame_rise, input, 1, meaning frame lane captured on the rising edge.
REQ-009 SHALL have port frame_fall, input, 1, meaning frame lane captured on the falling edge.
REQ-010 SHALL have port realign, input, 1, meaning single-cycle request to drop lock and re-search.
REQ-011 SHALL have port sample0, output, width, meaning earlier sample of the aligned pair.
REQ-012 SHALL have port sample1, output, width, meaning later sample of the aligned pair.
REQ-013 SHALL have port data_valid, output, 1, meaning sample0/sample1 are aligned and valid.
REQ-014 SHALL have port locked, output, 1, meaning FSM is in LOCKED.
REQ-015 SHALL have port slip, output, 1, meaning current half-cycle alignment select.
REQ-016 SHALL have port err_count, output, 16, meaning frame mismatches seen while LOCKED.

Function
REQ-017 SHALL keep prev_fall and prev_frame_fall registers holding data_fall and frame_fall from the previous cycle.
REQ-018 SHALL form the view at cycle n as follows: slip=0 -> s0=data_rise(n), s1=data_fall(n), f0=frame_rise(n), f1=frame_fall(n); slip=1 -> s0=prev_fall, s1=data_rise(n), f0=prev_frame_fall, f1=frame_rise(n).
REQ-019 SHALL register sample0=s0 and sample1=s1 every cycle, giving latency 1 cycle from data_rise.
REQ-020 SHALL define match as f0=1 and f1=0.
REQ-021 SHALL implement states SEARCH, CHECK, WAIT, LOCKED.
REQ-022 SHALL transition from SEARCH on match to CHECK with match counter=1, and on mismatch toggle slip and go to WAIT.
REQ-023 SHALL, in WAIT, ignore frame inputs for slip_wait cycles, then go to SEARCH.
REQ-024 SHALL, in CHECK, increment the match counter on match and go to LOCKED when the counter reaches lock_count; on mismatch, toggle slip, clear the counter and go to WAIT.
REQ-025 SHALL, in LOCKED, count consecutive mismatches, clear that count on any match, and on 4 consecutive mismatches toggle slip and go to WAIT.
REQ-026 SHALL, when realign is 1 in any state, go to SEARCH next cycle with counters cleared and slip unchanged; realign takes priority over every other transition.
REQ-027 SHALL drive locked=1 exactly while the state is LOCKED.
REQ-028 SHALL assert data_valid in the same cycle as the sample registers whose view was taken while the state was LOCKED.
REQ-029 SHALL toggle slip only on the transitions listed above.

Reset
REQ-030 SHALL, when reset=1 at a clk edge, force the state to SEARCH and clear slip, all counters, prev registers, sample0, sample1, data_valid, locked and err_count to 0.
REQ-031 SHALL give reset priority over realign and over all state transitions, including mid-CHECK or mid-WAIT.

Configuration
REQ-032 SHALL, with DDR_FRAME_ALIGN_ERRCNT_EN defined, increment err_count by 1 on each mismatch while LOCKED, saturate it at 16'hFFFF, and clear it only on reset.
REQ-033 SHALL, without DDR_FRAME_ALIGN_ERRCNT_EN, keep the err_count port and tie it to constant 0, with no counter logic.

Verification
REQ-034 SHALL verify: frame_rise=1, frame_fall=0 constantly after reset -> locked=1 after 16 matching cycles, slip=0, sample0 equals data_rise delayed by 1 cycle.
REQ-035 SHALL verify: frame_rise=0, frame_fall=1 constantly -> exactly one slip toggle, locked after SEARCH + 4 WAIT + 16 matching cycles, sample0 equals the prior cycle's data_fall.
REQ-036 SHALL verify: in LOCKED, 3 mismatches then a match -> lock held and err_count=3 (macro defined); 4 consecutive mismatches -> locked=0 and slip toggled.
REQ-037 SHALL verify: a realign pulse in LOCKED -> locked=0 and data_valid=0 next cycle, slip unchanged, relock after 16 matches.
REQ-038 SHALL verify: reset asserted mid-CHECK with counter=9 -> next cycle state SEARCH, slip=0, all outputs 0.
REQ-039 SHALL verify: without the macro, the REQ-036 stimulus -> err_count stays 0.
